// File: rtl/spi_pixel_loader.sv
// SPI byte-stream to framebuffer loader: pixel writes, fill, errors.
// Ports: clk, reset, rx_byte/rx_done/rx_idle in; fb_* writes, status out.
module spi_pixel_loader #(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_done,
  input  logic                  rx_idle,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [23:0]           fb_wdata,
  output logic                  frame_done,
  output logic                  busy,
  output logic [2:0]            err_flags
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PIX,
    FILL_COLOR,
    FILL_RUN,
    DISCARD
  } state_t;

  localparam logic [ADDR_WIDTH:0] NPIX =
    (ADDR_WIDTH+1)'(NUM_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_PIXELS-1);
  localparam logic [ADDR_WIDTH-1:0] PMAX = '1;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            g_q, g_d;
  logic [7:0]            r_q, r_d;
  logic [23:0]           color_q, color_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic                  pwe_q, pwe_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [23:0]           pdata_q, pdata_d;
  logic                  dirty_q, dirty_d;
  logic                  fd_q, fd_d;
  logic [2:0]            err_q, err_d;
  logic                  byte_ok;

  // Fill writes are combinational from state so busy and fb_we
  // cover exactly the same NUM_PIXELS cycles.
  assign busy       = (state_q == FILL_RUN);
  assign fb_we      = busy | pwe_q;
  assign fb_addr    = busy ? fill_q : paddr_q;
  assign fb_wdata   = busy ? color_q : pdata_q;
  assign frame_done = fd_q;
  assign err_flags  = err_q;

  // rx_idle beats a coincident byte.
  assign byte_ok = rx_done & ~rx_idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    r_d     = r_q;
    color_d = color_q;
    fill_d  = fill_q;
    pwe_d   = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    dirty_d = dirty_q;
    fd_d    = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (byte_ok) begin
          cnt_d = 2'd0;
          if (rx_byte == 8'h01) begin
            state_d = ADDR;
          end else if (rx_byte == 8'h02) begin
            state_d = FILL_COLOR;
          end else begin
            state_d  = DISCARD;
            err_d[0] = 1'b1;
          end
        end
      end
      ADDR: begin
        if (byte_ok) begin
          ptr_d   = ADDR_WIDTH'(rx_byte);
          cnt_d   = 2'd0;
          state_d = PIX;
        end
      end
      PIX, FILL_COLOR: begin
        if (byte_ok) begin
          unique case (cnt_q)
            2'd0: begin
              g_d   = rx_byte;
              cnt_d = 2'd1;
            end
            2'd1: begin
              r_d   = rx_byte;
              cnt_d = 2'd2;
            end
            default: begin
              cnt_d = 2'd0;
              if (state_q == PIX) begin
                if ({1'b0, ptr_q} < NPIX) begin
                  pwe_d   = 1'b1;
                  paddr_d = ptr_q;
                  pdata_d = {g_q, r_q, rx_byte};
                end else begin
                  err_d[1] = 1'b1;
                end
                if (ptr_q != PMAX) begin
                  ptr_d = ptr_q + 1'b1;
                end
              end else begin
                color_d = {g_q, r_q, rx_byte};
                fill_d  = '0;
                state_d = FILL_RUN;
              end
            end
          endcase
        end
      end
      FILL_RUN: begin
        if (rx_done) begin
          err_d[2] = 1'b1;
        end
        fill_d = fill_q + 1'b1;
        if (fill_q == LAST) begin
          state_d = rx_idle ? IDLE : DISCARD;
        end
      end
      DISCARD: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame delimiter: drop any partial pixel.
    if (rx_idle && state_q != FILL_RUN) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end

    dirty_d = dirty_q | fb_we;
    if (state_d == IDLE && state_q != IDLE && dirty_d) begin
      fd_d    = 1'b1;
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      g_q     <= '0;
      r_q     <= '0;
      color_q <= '0;
      fill_q  <= '0;
      pwe_q   <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      dirty_q <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      r_q     <= r_d;
      color_q <= color_d;
      fill_q  <= fill_d;
      pwe_q   <= pwe_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      dirty_q <= dirty_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Directed bench for spi_pixel_loader.
// Vector table for framed byte streams, plus fill and reset sequences.
module tb_spi_pixel_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        rx_idle;
  logic        fb_we;
  logic [7:0]  fb_addr;
  logic [23:0] fb_wdata;
  logic        frame_done;
  logic        busy;
  logic [2:0]  err_flags;

  spi_pixel_loader #(
    .NUM_PIXELS(64),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .rx_idle   (rx_idle),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .frame_done(frame_done),
    .busy      (busy),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        idle;
    logic [7:0]  b;
    logic        we;
    logic [7:0]  addr;
    logic [23:0] data;
    logic        fd;
    logic [2:0]  err;
  } vec_t;

  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic d, input logic i,
                     input logic [7:0] b, input logic we,
                     input logic [7:0] a, input logic [23:0] dat,
                     input logic fd, input logic [2:0] e);
    vec_t v;
    v.done = d; v.idle = i; v.b = b; v.we = we;
    v.addr = a; v.data = dat; v.fd = fd; v.err = e;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(input logic d, input logic i,
                      input logic [7:0] b);
    rx_done = d;
    rx_idle = i;
    rx_byte = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr;
    reset   = 1'b0;
    rx_byte = 8'h00;
    rx_done = 1'b0;
    rx_idle = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst we", 32'(fb_we), 32'd0);
    chk("rst addr", 32'(fb_addr), 32'd0);
    chk("rst data", 32'(fb_wdata), 32'd0);
    chk("rst fd", 32'(frame_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err_flags), 32'd0);
    #19 reset = 1'b0;

    // single pixel at 5
    add(1,0,8'h01, 0,0,0,0,3'b000);
    add(1,0,8'h05, 0,0,0,0,3'b000);
    add(1,0,8'h10, 0,0,0,0,3'b000);
    add(1,0,8'h20, 0,0,0,0,3'b000);
    add(1,0,8'h30, 1,8'h05,24'h102030,0,3'b000);
    add(0,1,8'h00, 0,0,0,1,3'b000);
    add(0,0,8'h00, 0,0,0,0,3'b000);
    // partial pixel dropped, next frame fine
    add(1,0,8'h01, 0,0,0,0,3'b000);
    add(1,0,8'h00, 0,0,0,0,3'b000);
    add(1,0,8'h11, 0,0,0,0,3'b000);
    add(1,0,8'h22, 0,0,0,0,3'b000);
    add(0,1,8'h00, 0,0,0,0,3'b000);
    add(1,0,8'h01, 0,0,0,0,3'b000);
    add(1,0,8'h00, 0,0,0,0,3'b000);
    add(1,0,8'hAA, 0,0,0,0,3'b000);
    add(1,0,8'hBB, 0,0,0,0,3'b000);
    add(1,0,8'hCC, 1,8'h00,24'hAABBCC,0,3'b000);
    add(0,1,8'h00, 0,0,0,1,3'b000);
    add(0,0,8'h00, 0,0,0,0,3'b000);
    // idle and done together: byte ignored
    add(1,0,8'h01, 0,0,0,0,3'b000);
    add(1,0,8'h05, 0,0,0,0,3'b000);
    add(1,0,8'h10, 0,0,0,0,3'b000);
    add(1,0,8'h20, 0,0,0,0,3'b000);
    add(1,1,8'h30, 0,0,0,0,3'b000);
    add(0,0,8'h00, 0,0,0,0,3'b000);
    // range: write 63, then suppressed
    add(1,0,8'h01, 0,0,0,0,3'b000);
    add(1,0,8'h3F, 0,0,0,0,3'b000);
    add(1,0,8'hAA, 0,0,0,0,3'b000);
    add(1,0,8'hBB, 0,0,0,0,3'b000);
    add(1,0,8'hCC, 1,8'h3F,24'hAABBCC,0,3'b000);
    add(1,0,8'h11, 0,0,0,0,3'b000);
    add(1,0,8'h22, 0,0,0,0,3'b000);
    add(1,0,8'h33, 0,0,0,0,3'b010);
    add(0,1,8'h00, 0,0,0,1,3'b010);
    add(0,0,8'h00, 0,0,0,0,3'b010);
    // bad command then discarded pixel
    add(1,0,8'h07, 0,0,0,0,3'b011);
    add(1,0,8'h01, 0,0,0,0,3'b011);
    add(1,0,8'h00, 0,0,0,0,3'b011);
    add(1,0,8'hFF, 0,0,0,0,3'b011);
    add(1,0,8'hFF, 0,0,0,0,3'b011);
    add(1,0,8'hFF, 0,0,0,0,3'b011);
    add(0,1,8'h00, 0,0,0,0,3'b011);
    add(0,0,8'h00, 0,0,0,0,3'b011);

    foreach (vq[k]) begin
      step(vq[k].done, vq[k].idle, vq[k].b);
      chk($sformatf("v%0d we", k), 32'(fb_we), 32'(vq[k].we));
      chk($sformatf("v%0d fd", k), 32'(frame_done), 32'(vq[k].fd));
      chk($sformatf("v%0d err", k), 32'(err_flags), 32'(vq[k].err));
      if (vq[k].we) begin
        chk($sformatf("v%0d addr", k), 32'(fb_addr), 32'(vq[k].addr));
        chk($sformatf("v%0d data", k), 32'(fb_wdata), 32'(vq[k].data));
      end
    end

    // fill with overrun byte and rx_idle at the end
    step(1, 0, 8'h02);
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("fill%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("fill%0d we", i), 32'(fb_we), 32'd1);
      chk($sformatf("fill%0d addr", i), 32'(fb_addr), 32'(i));
      chk($sformatf("fill%0d data", i), 32'(fb_wdata), 32'h010203);
      step(i == 5, i >= 20, 8'h55);
    end
    chk("fill end busy", 32'(busy), 32'd0);
    chk("fill end we", 32'(fb_we), 32'd0);
    chk("fill end fd", 32'(frame_done), 32'd1);
    chk("fill end err", 32'(err_flags), 32'b111);
    step(0, 0, 8'h00);
    chk("fill fd pulse", 32'(frame_done), 32'd0);

    // reset in the middle of a fill
    step(1, 0, 8'h02);
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    step(1, 0, 8'hCC);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00);
    chk("mid addr", 32'(fb_addr), 32'd10);
    chk("mid busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst we", 32'(fb_we), 32'd0);
    chk("arst addr", 32'(fb_addr), 32'd0);
    chk("arst data", 32'(fb_wdata), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst err", 32'(err_flags), 32'd0);
    chk("arst fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    wr = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (fb_we) wr++;
    end
    chk("post rst writes", 32'(wr), 32'd0);
    chk("post rst busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_pixel_loader.md
SPI_PIXEL_LOADER -- requirements
Module: spi_pixel_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 64, number of framebuffer entries (1..256).
REQ-002 Parameter ADDR_WIDTH, default 8, framebuffer address width.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_byte  input  8  received SPI byte, valid when rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe per received byte.
REQ-007 rx_idle  input  1  SPI timeout-expired level; high means no transfer in progress (frame delimiter).
REQ-008 fb_we  output  1  one-cycle framebuffer write strobe.
REQ-009 fb_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-010 fb_wdata  output  24  pixel data {G,R,B}.
REQ-011 frame_done  output  1  one-cycle pulse: frame finished with at least one pixel written.
REQ-012 busy  output  1  high while in FILL_RUN.
REQ-013 err_flags  output  3  sticky {overrun, range, bad_cmd}.

Function
REQ-014 States: IDLE, ADDR, PIX, FILL_COLOR, FILL_RUN, DISCARD; state changes only on rx_done, rx_idle, or fill completion.
REQ-015 IDLE + rx_done: byte 0x01 -> ADDR; 0x02 -> FILL_COLOR; other -> DISCARD with bad_cmd set.
REQ-016 ADDR + rx_done: load pointer <= rx_byte, clear byte counter, -> PIX.
REQ-017 PIX: bytes collected in order G,R,B with 2-bit counter 0..2; counter wraps to 0 after B.
REQ-018 Third byte (B) sampled in cycle N -> fb_we=1, fb_addr=pointer, fb_wdata={G,R,B} in cycle N+1; pointer increments after write.
REQ-019 Pointer >= NUM_PIXELS at write time: fb_we suppressed, range error set, pointer still increments, saturating at 2^ADDR_WIDTH-1.
REQ-020 FILL_COLOR: collect G,R,B as in PIX; after B -> FILL_RUN with fill address 0.
REQ-021 FILL_RUN: fb_we=1 every cycle, fb_addr 0..NUM_PIXELS-1, fb_wdata = fill colour; exactly NUM_PIXELS writes, then IDLE if rx_idle=1, else DISCARD.
REQ-022 rx_done during FILL_RUN: byte dropped, overrun error set, fill unaffected.
REQ-023 DISCARD: ignore all bytes until rx_idle.
REQ-024 rx_idle=1 in any state except FILL_RUN: -> IDLE next cycle, partial pixel (counter != 0) discarded without write.
REQ-025 rx_idle=1 and rx_done=1 in same cycle: rx_idle wins, byte ignored.
REQ-026 Dirty flag set on every performed write, cleared on frame_done.
REQ-027 frame_done=1 for one cycle in the cycle state enters IDLE with dirty=1; never asserted while busy=1.
REQ-028 err_flags bits are sticky until reset; multiple bits may be set.
REQ-029 fb_we never high for two consecutive cycles outside FILL_RUN.

Reset
REQ-030 Reset asserted: state=IDLE, counter=0, pointer=0, dirty=0, fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, busy=0, err_flags=0, immediately and asynchronously.
REQ-031 Reset mid-FILL_RUN aborts fill; no further writes after deassertion.
REQ-032 First state change no earlier than first rising clk edge after reset release.

Verification
REQ-033 Bytes 01,05,10,20,30 then rx_idle -> one write addr 5 data 0x102030, then frame_done pulse.
REQ-034 Bytes 01,3F,AA,BB,CC,11,22,33 (NUM_PIXELS=64) -> write addr 63 data 0xAABBCC, second write suppressed, err_flags=3'b010.
REQ-035 Bytes 02,01,02,03 -> 64 consecutive writes addr 0..63 data 0x010203, busy high throughout; extra byte during fill sets overrun.
REQ-036 Byte 07 then 01,00,FF,FF,FF -> no writes, bad_cmd set, no frame_done at rx_idle.
REQ-037 Bytes 01,00,11,22 then rx_idle -> no write, no frame_done; next frame 01,00,AA,BB,CC writes 0xAABBCC at addr 0.
REQ-038 Reset pulse at fill address 10 -> outputs zero at once, no writes after release.
